// File: rtl/kmeans_pkg.sv
// Shared types and default sizes for the k-means centroid accumulation stage.
package kmeans_pkg;

  localparam int CENTROID_NUM = 8;
  localparam int COORD_NUM    = 7;
  localparam int CORD_W       = 13;
  localparam int ACC_W        = 22;
  localparam int CNT_W        = 10;
  localparam int DATA_W       = COORD_NUM * CORD_W;
  localparam int IDX_W        = $clog2(CENTROID_NUM);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef logic [DATA_W-1:0]          point_t;
  typedef logic [COORD_NUM*ACC_W-1:0] accum_t;

endpackage

// File: rtl/centroid_accumulator_if.sv
// Point-in and drain-out handshake channels of the centroid accumulator.
interface centroid_accumulator_if;
  import kmeans_pkg::*;

  logic             pt_valid;
  logic             pt_ready;
  point_t           pt_data;
  logic [IDX_W-1:0] pt_cent;
  logic             pt_last;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  accum_t           out_accum;
  logic [CNT_W-1:0] out_count;

  modport master (
    output pt_valid, pt_data, pt_cent, pt_last, out_ready,
    input  pt_ready, out_valid, out_idx, out_accum, out_count
  );

  modport slave (
    input  pt_valid, pt_data, pt_cent, pt_last, out_ready,
    output pt_ready, out_valid, out_idx, out_accum, out_count
  );

endinterface

// File: rtl/coord_sat_adder.sv
// Multi-lane signed saturating add: accumulator lanes plus sign-extended coordinates.
module coord_sat_adder #(
  parameter int coord_num        = 7,
  parameter int cordinate_width  = 13,
  parameter int accum_cord_width = 22
) (
  input  logic [coord_num*accum_cord_width-1:0] sum,
  input  logic [coord_num*cordinate_width-1:0]  coord,
  output logic [coord_num*accum_cord_width-1:0] result,
  output logic                                  sat
);

  localparam int AW = accum_cord_width;
  localparam int CW = cordinate_width;

  logic [coord_num-1:0] lane_sat;

  genvar k;
  generate
    for (k = 0; k < coord_num; k++) begin : g_lane
      logic [AW:0] a_ext;
      logic [AW:0] c_ext;
      logic [AW:0] s;

      // One guard bit: overflow shows up as the top two bits disagreeing.
      assign a_ext = {sum[k*AW+AW-1], sum[k*AW +: AW]};
      assign c_ext = {{(AW+1-CW){coord[k*CW+CW-1]}}, coord[k*CW +: CW]};
      assign s     = a_ext + c_ext;
      assign lane_sat[k] = s[AW] ^ s[AW-1];
      assign result[k*AW +: AW] = !lane_sat[k] ? s[AW-1:0] :
                                  (s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}});
    end
  endgenerate

  assign sat = |lane_sat;

endmodule

// File: rtl/centroid_accumulator.sv
// Per-centroid coordinate sums and point counts for one k-means pass, drained
// one centroid at a time to the divider stage.
module centroid_accumulator
  import kmeans_pkg::*;
#(
  parameter int centroid_num     = CENTROID_NUM,
  parameter int coord_num        = COORD_NUM,
  parameter int cordinate_width  = CORD_W,
  parameter int accum_cord_width = ACC_W,
  parameter int count_width      = CNT_W,
  parameter int dataWidth        = DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  centroid_accumulator_if.slave   bus,
  output logic                    pass_done,
  output logic                    busy,
  output logic                    sat_err,
  output logic                    drop_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(centroid_num - 1);

  state_t state_q, state_d;

  accum_t                 sum_q [centroid_num];
  logic [count_width-1:0] cnt_q [centroid_num];
  logic [IDX_W-1:0]       out_idx_q;
  logic                   pass_done_q;

  logic [dataWidth-1:0]   pt_word;
  accum_t                 add_result;
  logic                   add_sat;
  logic                   accept;
  logic                   drain_hs;
  logic                   cnt_full;

  assign pt_word  = bus.pt_data;
  assign accept   = bus.pt_valid && bus.pt_ready;
  assign drain_hs = bus.out_valid && bus.out_ready;
  assign cnt_full = &cnt_q[bus.pt_cent];

  coord_sat_adder #(
    .coord_num        (coord_num),
    .cordinate_width  (cordinate_width),
    .accum_cord_width (accum_cord_width)
  ) u_adder (
    .sum    (sum_q[bus.pt_cent]),
    .coord  (pt_word),
    .result (add_result),
    .sat    (add_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_ACCUM;
      ST_ACCUM: if (accept && bus.pt_last) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_hs && out_idx_q == LAST_IDX) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are forced low while rst is held, before the edge lands.
  always_comb begin
    bus.pt_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    if (!rst) begin
      bus.pt_ready  = (state_q == ST_ACCUM);
      bus.out_valid = (state_q == ST_DRAIN);
      busy          = (state_q != ST_IDLE);
    end
  end

  assign bus.out_idx   = out_idx_q;
  assign bus.out_accum = bus.out_valid ? sum_q[out_idx_q] : '0;
  assign bus.out_count = bus.out_valid ? CNT_W'(cnt_q[out_idx_q]) : '0;
  assign pass_done     = pass_done_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < centroid_num; i++) begin
        sum_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      out_idx_q   <= '0;
      sat_err     <= 1'b0;
      drop_err    <= 1'b0;
      pass_done_q <= 1'b0;
    end else begin
      pass_done_q <= 1'b0;
      if (state_q == ST_IDLE && start) begin
        for (int i = 0; i < centroid_num; i++) begin
          sum_q[i] <= '0;
          cnt_q[i] <= '0;
        end
        out_idx_q <= '0;
        sat_err   <= 1'b0;
        drop_err  <= 1'b0;
      end
      // A full counter drops the whole point so sum and count stay consistent.
      if (accept) begin
        if (cnt_full) begin
          drop_err <= 1'b1;
        end else begin
          sum_q[bus.pt_cent] <= add_result;
          cnt_q[bus.pt_cent] <= cnt_q[bus.pt_cent] + 1'b1;
          if (add_sat) sat_err <= 1'b1;
        end
      end
      if (drain_hs) begin
        if (out_idx_q == LAST_IDX) begin
          out_idx_q   <= '0;
          pass_done_q <= 1'b1;
        end else begin
          out_idx_q <= out_idx_q + 1'b1;
        end
      end
    end
  end

endmodule
